// File: rtl/magic_multi.sv
// Magic-button NMI controller: traps into a mapped monitor ROM on NMI and exposes a small
// config/mask register file through an I/O port while the monitor is mapped.
module magic_multi #(
  parameter int unsigned             NSRC     = 2,
  parameter int unsigned             NCFG     = 8,
  parameter int unsigned             CFG_W    = 8,
  parameter logic [NCFG*CFG_W-1:0]   CFG_RST  = '0,
  parameter logic [15:0]             ENTRY_A  = 16'h0066,
  parameter logic [15:0]             EXIT_A   = 16'hF000,
  parameter logic [15:0]             REMAP_A  = 16'hF008,
  parameter logic [7:0]              CFG_PORT = 8'hFF
) (
  input  logic                    clk28,
  input  logic                    rst,
  input  logic [15:0]             a,
  input  logic [7:0]              d_in,
  input  logic                    mreq,
  input  logic                    iorq,
  input  logic                    rd,
  input  logic                    wr,
  input  logic                    m1,
  input  logic                    n_int,
  input  logic                    n_int_next,
  input  logic [NSRC-1:0]         nmi_req,
  output logic                    n_nmi,
  output logic                    magic_mode,
  output logic                    magic_map,
  output logic                    magic_active_next,
  output logic [NSRC-1:0]         cause,
  output logic [NCFG*CFG_W-1:0]   cfg,
  output logic [7:0]              d_out,
  output logic                    d_oe
);

  typedef enum logic [2:0] {
    StIdle,
    StNmiWait,
    StMapped,
    StUnmapPend,
    StRemapPend,
    StRemapWait
  } state_e;

  state_e                  state_q, state_d;
  logic                    magic_mode_q, magic_mode_d;
  logic                    magic_map_q, magic_map_d;
  logic [NSRC-1:0]         cause_q, cause_d;
  logic [NSRC-1:0]         mask_q, mask_d;
  logic [NCFG*CFG_W-1:0]   cfg_q, cfg_d;

  logic       pending;
  logic       trigger;
  logic       exit_hit;
  logic       remap_hit;
  logic       cfg_cs;
  logic [3:0] idx;

  assign pending   = |(nmi_req & mask_q);
  assign trigger   = pending && n_int && !n_int_next;
  assign exit_hit  = (state_q == StMapped) && mreq && rd && (a == EXIT_A);
  assign remap_hit = (state_q == StMapped) && mreq && rd && (a == REMAP_A);
  assign idx       = a[15:12];
  // Exit/remap reads win over the config decode.
  assign cfg_cs    = magic_map_q && iorq && (a[7:0] == CFG_PORT) && !exit_hit && !remap_hit;

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q      <= StIdle;
      magic_mode_q <= 1'b0;
      magic_map_q  <= 1'b0;
      cause_q      <= '0;
      mask_q       <= '1;
      cfg_q        <= CFG_RST;
    end else begin
      state_q      <= state_d;
      magic_mode_q <= magic_mode_d;
      magic_map_q  <= magic_map_d;
      cause_q      <= cause_d;
      mask_q       <= mask_d;
      cfg_q        <= cfg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    magic_mode_d = magic_mode_q;
    magic_map_d  = magic_map_q;
    cause_d      = cause_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          cause_d      = nmi_req & mask_q;
          magic_mode_d = 1'b1;
          state_d      = StNmiWait;
        end
      end
      StNmiWait: begin
        if (m1 && mreq && (a == ENTRY_A)) begin
          magic_map_d = 1'b1;
          state_d     = StMapped;
        end
      end
      StMapped: begin
        if (exit_hit) begin
          magic_mode_d = 1'b0;
          state_d      = StUnmapPend;
        end else if (remap_hit) begin
          state_d = StRemapPend;
        end
      end
      StUnmapPend: begin
        if (!mreq) begin
          magic_map_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StRemapPend: begin
        if (!mreq) begin
          magic_map_d = 1'b0;
          state_d     = StRemapWait;
        end
      end
      StRemapWait: begin
        if (m1 && mreq) begin
          magic_map_d = 1'b1;
          state_d     = StMapped;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Register file writes; indices between NCFG and 14 fall through untouched.
  always_comb begin
    cfg_d  = cfg_q;
    mask_d = mask_q;
    if (cfg_cs && wr) begin
      for (int i = 0; i < int'(NCFG); i++) begin
        if (idx == 4'(i)) cfg_d[i*CFG_W +: CFG_W] = d_in[CFG_W-1:0];
      end
      if (idx == 4'hF) mask_d = d_in[NSRC-1:0];
    end
  end

  always_comb begin
    d_out = 8'hFF;
    if (idx == 4'hF) begin
      d_out             = '0;
      d_out[NSRC-1:0]   = mask_q;
    end else if (idx == 4'hE) begin
      d_out             = '0;
      d_out[NSRC-1:0]   = cause_q;
    end else begin
      for (int i = 0; i < int'(NCFG); i++) begin
        if (idx == 4'(i)) begin
          d_out            = '0;
          d_out[CFG_W-1:0] = cfg_q[i*CFG_W +: CFG_W];
        end
      end
    end
  end

  always_comb begin
    n_nmi             = !magic_mode_q;
    magic_mode        = magic_mode_q;
    magic_map         = magic_map_q;
    magic_active_next = pending;
    cause             = cause_q;
    cfg               = cfg_q;
    d_oe              = cfg_cs && rd;
  end

endmodule

// File: tb/tb_magic_multi.sv
// Bench for magic_multi: NMI entry/exit/remap sequences plus a table of config port accesses.
module tb_magic_multi;

  localparam logic [63:0] CfgRst = 64'h0807060504030201;

  logic        clk28 = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic        mreq, iorq, rd, wr, m1;
  logic        n_int, n_int_next;
  logic [1:0]  nmi_req;
  logic        n_nmi, magic_mode, magic_map, magic_active_next;
  logic [1:0]  cause;
  logic [63:0] cfg;
  logic [7:0]  d_out;
  logic        d_oe;

  magic_multi #(
    .NSRC    (2),
    .NCFG    (8),
    .CFG_W   (8),
    .CFG_RST (CfgRst)
  ) dut (
    .clk28             (clk28),
    .rst               (rst),
    .a                 (a),
    .d_in              (d_in),
    .mreq              (mreq),
    .iorq              (iorq),
    .rd                (rd),
    .wr                (wr),
    .m1                (m1),
    .n_int             (n_int),
    .n_int_next        (n_int_next),
    .nmi_req           (nmi_req),
    .n_nmi             (n_nmi),
    .magic_mode        (magic_mode),
    .magic_map         (magic_map),
    .magic_active_next (magic_active_next),
    .cause             (cause),
    .cfg               (cfg),
    .d_out             (d_out),
    .d_oe              (d_oe)
  );

  always #5 clk28 = ~clk28;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } sb_item_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  rd_exp;
  } vec_t;

  sb_item_t    sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_cfg;
  logic [1:0]  exp_mask;

  task automatic exp_push(input string n, input logic [63:0] v);
    sb.push_back('{n, v});
  endtask

  task automatic sb_check(input logic [63:0] act);
    sb_item_t it;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got=%0h", act);
      return;
    end
    it = sb.pop_front();
    if (act !== it.exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", it.name, act, it.exp);
    end
  endtask

  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  task automatic bus(input logic mr, input logic io, input logic r, input logic w, input logic m,
                     input logic [15:0] ad, input logic [7:0] dd);
    mreq = mr; iorq = io; rd = r; wr = w; m1 = m; a = ad; d_in = dd;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic fire(input logic [1:0] src);
    nmi_req = src; n_int = 1'b1; n_int_next = 1'b0;
    step();
    n_int_next = 1'b1;
  endtask

  task automatic fetch(input logic [15:0] ad);
    bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ad, 8'h00);
    step();
    idle();
  endtask

  task automatic mem_rd(input logic [15:0] ad);
    bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ad, 8'h00);
    step();
  endtask

  task automatic io_write(input logic [15:0] ad, input logic [7:0] dd, input logic mapped);
    int i;
    i = int'(ad[15:12]);
    bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ad, dd);
    step();
    idle();
    if (mapped) begin
      if (i < 8) exp_cfg[i*8 +: 8] = dd;
      if (i == 15) exp_mask = dd[1:0];
    end
  endtask

  task automatic io_read(input string n, input logic [15:0] ad, input logic oe,
                         input logic [7:0] dexp);
    bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ad, 8'h00);
    exp_push({n, "_oe"}, 64'(oe));
    if (oe) exp_push({n, "_dout"}, 64'(dexp));
    @(negedge clk28);
    sb_check(64'(d_oe));
    if (oe) sb_check(64'(d_out));
    step();
    idle();
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h3FFF, 8'h02, 8'h02};
    vecs[1] = '{16'h0FFF, 8'hA5, 8'hA5};
    vecs[2] = '{16'h7FFF, 8'h3C, 8'h3C};
    vecs[3] = '{16'hAFFF, 8'h77, 8'hFF};
    vecs[4] = '{16'hDFFF, 8'h12, 8'hFF};
    vecs[5] = '{16'hEFFF, 8'h99, 8'h01};

    exp_cfg = CfgRst;
    exp_mask = 2'b11;
    rst = 1'b1; nmi_req = 2'b00; n_int = 1'b1; n_int_next = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;

    exp_push("rst_n_nmi", 64'd1);
    exp_push("rst_map", 64'd0);
    exp_push("rst_mode", 64'd0);
    exp_push("rst_cause", 64'd0);
    exp_push("rst_cfg", CfgRst);
    sb_check(64'(n_nmi));
    sb_check(64'(magic_map));
    sb_check(64'(magic_mode));
    sb_check(64'(cause));
    sb_check(cfg);

    // Entry, map, exit, unmap.
    nmi_req = 2'b01; n_int_next = 1'b0;
    #1;
    exp_push("active_next", 64'd1);
    sb_check(64'(magic_active_next));
    fire(2'b01);
    exp_push("entry_n_nmi", 64'd0);
    exp_push("entry_cause", 64'd1);
    sb_check(64'(n_nmi));
    sb_check(64'(cause));
    fetch(16'h0066);
    exp_push("entry_map", 64'd1);
    sb_check(64'(magic_map));
    step();
    mem_rd(16'hF000);
    exp_push("exit_mode", 64'd0);
    exp_push("exit_n_nmi", 64'd1);
    exp_push("exit_map_held", 64'd1);
    sb_check(64'(magic_mode));
    sb_check(64'(n_nmi));
    sb_check(64'(magic_map));
    idle();
    step();
    exp_push("unmap_map", 64'd0);
    sb_check(64'(magic_map));

    // Remap: F008 drops the map, next M1 anywhere brings it back.
    fire(2'b01);
    fetch(16'h0066);
    mem_rd(16'hF008);
    exp_push("remap_mode", 64'd1);
    sb_check(64'(magic_mode));
    idle();
    step();
    exp_push("remap_unmapped", 64'd0);
    sb_check(64'(magic_map));
    fetch(16'h1234);
    exp_push("remap_map", 64'd1);
    exp_push("remap_n_nmi", 64'd0);
    sb_check(64'(magic_map));
    sb_check(64'(n_nmi));

    for (int k = 0; k < 6; k++) begin
      io_write(vecs[k].addr, vecs[k].data, 1'b1);
      exp_push($sformatf("vec%0d_cfg", k), exp_cfg);
      sb_check(cfg);
      io_read($sformatf("vec%0d_rd", k), vecs[k].addr, 1'b1, vecs[k].rd_exp);
    end

    // Unmapped accesses are ignored.
    mem_rd(16'hF000);
    idle();
    step();
    io_write(16'h3FFF, 8'h55, 1'b0);
    exp_push("unmapped_cfg", exp_cfg);
    sb_check(cfg);
    io_read("unmapped_rd", 16'h3FFF, 1'b0, 8'h00);

    // Mask filters triggers.
    fire(2'b01);
    fetch(16'h0066);
    io_write(16'hFFFF, 8'h02, 1'b1);
    io_read("mask_rd", 16'hFFFF, 1'b1, 8'(exp_mask));
    mem_rd(16'hF000);
    idle();
    step();
    nmi_req = 2'b01; n_int_next = 1'b0;
    #1;
    exp_push("masked_active", 64'd0);
    sb_check(64'(magic_active_next));
    fire(2'b01);
    exp_push("masked_n_nmi", 64'd1);
    sb_check(64'(n_nmi));
    nmi_req = 2'b10; n_int_next = 1'b0;
    #1;
    exp_push("src1_active", 64'd1);
    sb_check(64'(magic_active_next));
    fire(2'b10);
    exp_push("src1_n_nmi", 64'd0);
    exp_push("src1_cause", 64'd2);
    sb_check(64'(n_nmi));
    sb_check(64'(cause));
    fetch(16'h0066);
    io_read("cause_rd", 16'hEEFF, 1'b1, 8'h02);

    // Reset while mapped beats a simultaneous write.
    io_write(16'h0FFF, 8'h5A, 1'b1);
    exp_push("pre_rst_cfg0", 64'h5A);
    sb_check(64'(cfg[7:0]));
    rst = 1'b1;
    bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0FFF, 8'h11);
    nmi_req = 2'b11; n_int_next = 1'b0;
    step();
    rst = 1'b0; n_int_next = 1'b1; nmi_req = 2'b00;
    idle();
    exp_cfg = CfgRst;
    exp_mask = 2'b11;
    exp_push("rst2_map", 64'd0);
    exp_push("rst2_n_nmi", 64'd1);
    exp_push("rst2_cause", 64'd0);
    exp_push("rst2_cfg", exp_cfg);
    sb_check(64'(magic_map));
    sb_check(64'(n_nmi));
    sb_check(64'(cause));
    sb_check(cfg);
    fire(2'b01);
    exp_push("rst2_trigger", 64'd0);
    sb_check(64'(n_nmi));
    fetch(16'h0066);
    io_read("rst2_mask", 16'hFFFF, 1'b1, 8'(exp_mask));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/magic_multi.md
MAGIC_MULTI -- requirements
Module: magic_multi

Interface
REQ-001 SHALL have parameter NSRC, default 2, meaning the number of NMI trigger sources (1..8).
REQ-002 SHALL have parameter NCFG, default 8, meaning the number of config registers (1..14).
REQ-003 SHALL have parameter CFG_W, default 8, meaning the config register width (1..8).
REQ-004 SHALL have parameter CFG_RST, default all zeros, meaning the flat NCFG*CFG_W reset vector, with register i at bits [i*CFG_W +: CFG_W].
REQ-005 SHALL have parameters ENTRY_A (16'h0066), EXIT_A (16'hF000), REMAP_A (16'hF008) and CFG_PORT (8'hFF), meaning the magic addresses and the config port low byte.
REQ-006 SHALL have ports: clk28 in 1, the single clock; rst in 1, reset, synchronous and active-high.
REQ-007 SHALL have ports: a in 16, CPU address; d_in in 8, CPU write data; mreq, iorq, rd, wr, m1 in 1 each, active-high decoded CPU strobes.
REQ-008 SHALL have ports: n_int, n_int_next in 1 each, the current and next-cycle INT level.
REQ-009 SHALL have port nmi_req in NSRC, level trigger requests; bit 0 is the magic button.
REQ-010 SHALL have outputs: n_nmi out 1; magic_mode out 1; magic_map out 1; magic_active_next out 1.
REQ-011 SHALL have outputs: cause out NSRC, latched trigger sources; cfg out NCFG*CFG_W.
REQ-012 SHALL have outputs: d_out out 8, readback data; d_oe out 1, readback enable.

Function
REQ-013 SHALL implement FSM states IDLE, NMI_WAIT, MAPPED, UNMAP_PEND, REMAP_PEND and REMAP_WAIT.
REQ-014 SHALL compute pending = |(nmi_req & mask), where mask is an NSRC-bit register.
REQ-015 SHALL drive magic_active_next = pending combinationally, in every state.
REQ-016 SHALL, in IDLE, when pending && n_int==1 && n_int_next==0: load cause <= nmi_req & mask, set magic_mode=1 and go to NMI_WAIT at the next clk28.
REQ-017 SHALL drive n_nmi = !magic_mode, registered-state derived, so it is low for the whole of magic mode.
REQ-018 SHALL, in NMI_WAIT, on m1 && mreq && a==ENTRY_A: set magic_map=1 and go to MAPPED.
REQ-019 SHALL, in MAPPED, on mreq && rd && a==EXIT_A: clear magic_mode in that cycle and go to UNMAP_PEND.
REQ-020 SHALL, in MAPPED, on mreq && rd && a==REMAP_A: go to REMAP_PEND, with magic_mode unchanged.
REQ-021 SHALL, in UNMAP_PEND, on !mreq: clear magic_map and go to IDLE; REMAP_PEND on !mreq SHALL clear magic_map and go to REMAP_WAIT.
REQ-022 SHALL, in REMAP_WAIT, on m1 && mreq at any address: set magic_map=1 and go to MAPPED.
REQ-023 SHALL ignore triggers outside IDLE; cause SHALL hold its value until the next trigger.
REQ-024 SHALL decode cfg_cs = magic_map && iorq && a[7:0]==CFG_PORT, with idx = a[15:12].
REQ-025 SHALL, on cfg_cs && wr with idx<NCFG, write cfg[idx] <= d_in[CFG_W-1:0] every cycle the strobe is held.
REQ-026 SHALL, on cfg_cs && wr with idx==15, write mask <= d_in[NSRC-1:0].
REQ-027 SHALL ignore writes with NCFG<=idx<=14.
REQ-028 SHALL drive d_oe = cfg_cs && rd, combinationally.
REQ-029 SHALL drive d_out as: cfg[idx] zero-extended for idx<NCFG; cause zero-extended for idx==14; mask zero-extended for idx==15; 8'hFF otherwise.
REQ-030 SHALL ignore config accesses while magic_map==0: no write, d_oe=0.
REQ-031 SHALL give EXIT_A and REMAP_A priority over config decode; if a==EXIT_A and a==REMAP_A both match, EXIT_A SHALL win.

Reset
REQ-032 SHALL, on rst high at a clk28 edge, regardless of state: set state=IDLE, magic_mode=0, magic_map=0, n_nmi=1, cause=0, mask=all ones and cfg=CFG_RST.
REQ-033 SHALL take priority for rst over every simultaneous event, including a trigger or a write in the same cycle.

Verification
REQ-034 SHALL cover: nmi_req=01 with an INT falling edge -> n_nmi low next cycle, cause=01; M1 fetch at 0066 -> magic_map=1; read of F000 -> magic_mode=0; mreq low -> magic_map=0, state IDLE.
REQ-035 SHALL cover: in MAPPED, read F008 then mreq low -> magic_map=0; next M1 at 1234 -> magic_map=1, n_nmi still low.
REQ-036 SHALL cover: mapped OUT to 0x3FFF with d=0x02 -> cfg[3]=0x02; IN from 0x3FFF -> d_oe=1, d_out=0x02; the same OUT while unmapped -> cfg[3] unchanged.
REQ-037 SHALL cover: write 0xFFFF with d=0x02 (mask=10); nmi_req=01 with an INT edge -> no NMI; nmi_req=10 -> NMI with cause=10, and IN from 0xEEFF returns 0x02.
REQ-038 SHALL cover: assert rst while in MAPPED with cfg[0]=0x5A -> next cycle magic_map=0, n_nmi=1, cfg[0]=CFG_RST[7:0], mask=all ones.
REQ-039 SHALL cover: with NCFG=8, OUT to 0xAFFF -> no register changes; IN from 0xAFFF -> d_out=0xFF.
